// File: rtl/gate_exhaustive_checker.sv
// gate_exhaustive_checker: exhaustive stimulus/response sequencer for N-input reduction gates.
// Optional macro GATE_CHK_STOP_ON_FAIL_EN ends a run at the first mismatching vector.
module gate_exhaustive_checker #(
   parameter int N_IN    = 3,
   parameter int GATE_OP = 0,
   parameter int SETTLE  = 1
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            start,
   output logic [N_IN-1:0] dut_in,
   input  logic            dut_out,
   output logic            busy,
   output logic            done,
   output logic            pass,
   output logic [N_IN:0]   err_count,
   output logic [N_IN-1:0] first_fail
);

   localparam int EW = N_IN + 1;
   localparam int CW = (SETTLE > 1) ? $clog2(SETTLE) : 1;
   localparam logic [CW-1:0] C_RELOAD = CW'(SETTLE - 1);
   localparam logic [N_IN-1:0] C_LAST = '1;
   localparam logic [EW-1:0] C_SAT = {1'b1, {N_IN{1'b0}}};

   typedef enum logic [1:0] {
      S_IDLE,
      S_SETTLE,
      S_CHECK,
      S_DONE
   } state_t;

   state_t          r_state;
   state_t          w_next;
   logic [N_IN-1:0] r_vec;
   logic [CW-1:0]   r_cnt;
   logic [EW-1:0]   r_err;
   logic [N_IN-1:0] r_first;
   logic            r_pass;
   logic            w_exp;
   logic            w_miss;
   logic            w_last;
   logic            w_stop;

   assign dut_in     = r_vec;
   assign err_count  = r_err;
   assign first_fail = r_first;
   assign pass       = r_pass;

   // Expected gate response for the vector currently applied.
   always_comb begin
      w_exp = 1'b0;
      case (GATE_OP)
         0:       w_exp = &r_vec;
         1:       w_exp = |r_vec;
         2:       w_exp = ^r_vec;
         3:       w_exp = ~&r_vec;
         4:       w_exp = ~|r_vec;
         5:       w_exp = ~^r_vec;
         default: w_exp = &r_vec;
      endcase
   end

   assign w_miss = (dut_out != w_exp);
   assign w_last = (r_vec == C_LAST);

`ifdef GATE_CHK_STOP_ON_FAIL_EN
   assign w_stop = w_last | w_miss;
`else
   assign w_stop = w_last;
`endif

   // State register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_next;
      end
   end

   // Next-state decode and handshake outputs.
   always_comb begin
      w_next = r_state;
      busy   = 1'b0;
      done   = 1'b0;
      unique case (r_state)
         S_IDLE: begin
            if (start) w_next = S_SETTLE;
         end
         S_SETTLE: begin
            busy = 1'b1;
            if (r_cnt == '0) w_next = S_CHECK;
         end
         S_CHECK: begin
            busy   = 1'b1;
            w_next = w_stop ? S_DONE : S_SETTLE;
         end
         S_DONE: begin
            done   = 1'b1;
            w_next = S_IDLE;
         end
         default: w_next = S_IDLE;
      endcase
   end

   // Vector, settle counter and result accumulation.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_vec   <= '0;
         r_cnt   <= '0;
         r_err   <= '0;
         r_first <= '0;
         r_pass  <= 1'b0;
      end else begin
         unique case (r_state)
            S_IDLE: begin
               if (start) begin
                  r_vec   <= '0;
                  r_cnt   <= C_RELOAD;
                  r_err   <= '0;
                  r_first <= '0;
                  r_pass  <= 1'b0;
               end
            end
            S_SETTLE: begin
               if (r_cnt != '0) r_cnt <= r_cnt - CW'(1);
            end
            S_CHECK: begin
               if (w_miss) begin
                  if (r_err != C_SAT) r_err <= r_err + EW'(1);
                  if (r_err == '0) r_first <= r_vec;
               end
               if (w_stop) begin
                  r_pass <= (r_err == '0) && !w_miss;
               end else begin
                  r_vec <= r_vec + N_IN'(1);
                  r_cnt <= C_RELOAD;
               end
            end
            S_DONE: begin
               r_pass <= r_pass;
            end
            default: begin
               r_vec <= r_vec;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_gate_exhaustive_checker.sv
// tb_gate_exhaustive_checker: scoreboard bench for gate_exhaustive_checker
// driving a 3-input AND model (correct, stuck-at-0, stuck-at-1).
module tb_gate_exhaustive_checker;

   localparam int N   = 3;
   localparam int S   = 1;
   localparam int NV  = 1 << N;

   typedef struct {
      int cyc;
      int err;
      int first;
      int last;
      bit pass;
   } exp_t;

   logic           clk = 1'b0;
   logic           rst_n = 1'b0;
   logic           start = 1'b0;
   logic [N-1:0]   dut_in;
   logic           dut_out;
   logic           busy;
   logic           done;
   logic           pass;
   logic [N:0]     err_count;
   logic [N-1:0]   first_fail;

   int mode = 0;
   int n_checks = 0;
   int n_fail = 0;
   exp_t sb[$];

   gate_exhaustive_checker #(
      .N_IN(N), .GATE_OP(0), .SETTLE(S)
   ) u_dut (
      .clk(clk), .rst_n(rst_n), .start(start),
      .dut_in(dut_in), .dut_out(dut_out),
      .busy(busy), .done(done), .pass(pass),
      .err_count(err_count), .first_fail(first_fail)
   );

   always #5 clk = ~clk;

   // Gate under test: good AND, or output stuck low/high.
   always_comb begin
      dut_out = 1'b0;
      case (mode)
         0: dut_out = &dut_in;
         1: dut_out = 1'b0;
         2: dut_out = 1'b1;
         default: dut_out = &dut_in;
      endcase
   end

   function automatic exp_t model(input int m);
      exp_t e;
      bit   g;
      bit   want;
      logic [N-1:0] v;
      e.err = 0;
      e.first = 0;
      e.last = NV - 1;
      for (int i = 0; i < NV; i++) begin
         v = N'(i);
         want = &v;
         g = (m == 0) ? want : (m == 2);
         if (g != want) begin
            if (e.err == 0) e.first = i;
            e.err++;
`ifdef GATE_CHK_STOP_ON_FAIL_EN
            e.last = i;
            break;
`endif
         end
      end
      e.pass = (e.err == 0);
      e.cyc = (e.last + 1) * (S + 1) + 1;
      return e;
   endfunction

   task automatic test_reset();
      rst_n = 1'b0;
      start = 1'b0;
      #12;
      n_checks++;
      if ({busy, done, pass} !== 3'b000) begin
         n_fail++;
         $display("FAIL reset_flags got=%b want=000", {busy, done, pass});
      end
      n_checks++;
      if (dut_in !== '0 || err_count !== '0 || first_fail !== '0) begin
         n_fail++;
         $display("FAIL reset_data got in=%0d err=%0d ff=%0d want 0/0/0",
                  dut_in, err_count, first_fail);
      end
      @(posedge clk);
      #1 rst_n = 1'b1;
      @(posedge clk);
      #1;
      n_checks++;
      if (busy !== 1'b0 || done !== 1'b0) begin
         n_fail++;
         $display("FAIL idle_after_reset got busy=%b done=%b want 0/0", busy, done);
      end
   endtask

   task automatic do_run(input int m, input string name, input bit rep);
      exp_t e;
      exp_t g;
      int   n;
      int   ev;
      bit   got;
      bit   seq_bad;
      string why;
      mode = m;
      e = model(m);
      sb.push_back(e);
      start = 1'b1;
      @(posedge clk);
      #1 start = 1'b0;
      n = 0;
      got = 0;
      seq_bad = 0;
      why = "";
      while (!got && n < 200) begin
         @(posedge clk);
         n++;
         #1;
         start = rep && (n == 2 || n == 8);
         ev = n / (S + 1);
         if (ev > e.last) ev = e.last;
         if (!seq_bad && dut_in !== N'(ev)) begin
            seq_bad = 1;
            $sformat(why, "n=%0d dut_in=%0d want %0d", n, dut_in, ev);
         end
         if (!seq_bad && busy !== (n < e.cyc - 1)) begin
            seq_bad = 1;
            $sformat(why, "n=%0d busy=%b want %b", n, busy, n < e.cyc - 1);
         end
         if (done) begin
            got = 1;
            g = sb.pop_front();
            n_checks++;
            if (n + 1 != g.cyc) begin
               n_fail++;
               $display("FAIL %s done_cycle got=%0d want=%0d", name, n + 1, g.cyc);
            end
            n_checks++;
            if (err_count !== (N + 1)'(g.err)) begin
               n_fail++;
               $display("FAIL %s err_count got=%0d want=%0d", name, err_count, g.err);
            end
            n_checks++;
            if (pass !== g.pass) begin
               n_fail++;
               $display("FAIL %s pass got=%b want=%b", name, pass, g.pass);
            end
            if (g.err != 0) begin
               n_checks++;
               if (first_fail !== N'(g.first)) begin
                  n_fail++;
                  $display("FAIL %s first_fail got=%0d want=%0d", name, first_fail, g.first);
               end
            end
            n_checks++;
            if (dut_in !== N'(g.last)) begin
               n_fail++;
               $display("FAIL %s final_dut_in got=%0d want=%0d", name, dut_in, g.last);
            end
         end
      end
      if (!got) begin
         n_checks++;
         n_fail++;
         $display("FAIL %s timeout got no done want done by cycle %0d", name, e.cyc);
         if (sb.size() > 0) void'(sb.pop_front());
      end
      n_checks++;
      if (seq_bad) begin
         n_fail++;
         $display("FAIL %s sequence %s", name, why);
      end
      seq_bad = 0;
      for (int k = 0; k < 3; k++) begin
         @(posedge clk);
         #1;
         if (done !== 1'b0 || busy !== 1'b0 || pass !== e.pass) seq_bad = 1;
      end
      n_checks++;
      if (seq_bad) begin
         n_fail++;
         $display("FAIL %s post_done got done=%b busy=%b pass=%b want 0/0/%b",
                  name, done, busy, pass, e.pass);
      end
   endtask

   task automatic test_mid_reset();
      bit bad;
      mode = 0;
      start = 1'b1;
      @(posedge clk);
      #1 start = 1'b0;
      repeat (5) @(posedge clk);
      #2 rst_n = 1'b0;
      #1;
      n_checks++;
      if ({busy, done, pass} !== 3'b000 || dut_in !== '0 ||
          err_count !== '0 || first_fail !== '0) begin
         n_fail++;
         $display("FAIL mid_reset_async got busy=%b done=%b pass=%b in=%0d err=%0d want all 0",
                  busy, done, pass, dut_in, err_count);
      end
      @(posedge clk);
      #1 rst_n = 1'b1;
      bad = 0;
      for (int k = 0; k < 20; k++) begin
         @(posedge clk);
         #1;
         if (done !== 1'b0 || busy !== 1'b0) bad = 1;
      end
      n_checks++;
      if (bad) begin
         n_fail++;
         $display("FAIL mid_reset_no_done got activity after abort want idle");
      end
      do_run(0, "after_reset", 1'b0);
   endtask

   task automatic test_held_start();
      int  n;
      bit  got;
      mode = 0;
      start = 1'b1;
      n = 0;
      got = 0;
      while (!got && n < 200) begin
         @(posedge clk);
         n++;
         #1;
         if (done) got = 1;
      end
      n_checks++;
      if (!got) begin
         n_fail++;
         $display("FAIL held_start timeout got no done want done");
      end
      @(posedge clk);
      #1;
      n_checks++;
      if (busy !== 1'b0 || done !== 1'b0) begin
         n_fail++;
         $display("FAIL held_start_idle got busy=%b done=%b want 0/0", busy, done);
      end
      @(posedge clk);
      #1 start = 1'b0;
      n_checks++;
      if (busy !== 1'b1 || dut_in !== '0 || pass !== 1'b0) begin
         n_fail++;
         $display("FAIL held_start_retrigger got busy=%b in=%0d pass=%b want 1/0/0",
                  busy, dut_in, pass);
      end
      n = 0;
      got = 0;
      while (!got && n < 200) begin
         @(posedge clk);
         n++;
         #1;
         if (done) got = 1;
      end
      n_checks++;
      if (!got || pass !== 1'b1) begin
         n_fail++;
         $display("FAIL held_start_second_run got done=%b pass=%b want 1/1", got, pass);
      end
      repeat (2) @(posedge clk);
      #1;
   endtask

   initial begin
      test_reset();
      do_run(0, "and_ok", 1'b0);
      do_run(1, "stuck0", 1'b0);
      do_run(2, "stuck1", 1'b0);
      do_run(0, "repulse", 1'b1);
      test_mid_reset();
      test_held_start();
      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/gate_exhaustive_checker.md
Name: gate_exhaustive_checker

Overview:
- Hardware stimulus/response engine for the combinational gate blocks (AND/OR/XOR/NAND families).
- Drives every input pattern of an N-input gate, waits for settling, samples the gate output and compares it with the expected value.
- Accumulates mismatches and reports pass/fail through a start/done handshake.
- Acts as the consuming end of a gate's input/output interface. It replaces hand-written vector lists with a synthesizable sequencer.

Parameters:
- N_IN, 3, number of gate inputs (1..8).
- GATE_OP, 0, expected function: 0=AND, 1=OR, 2=XOR, 3=NAND, 4=NOR, 5=XNOR (all reductions over N_IN bits).
- SETTLE, 1, wait cycles per vector before sampling (>=1).

Ports:
- clk  in  1  single clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  begin a run; sampled only in IDLE.
- dut_in  out  N_IN  registered vector driven to the gate inputs.
- dut_out  in  1  gate output under test.
- busy  out  1  high from the cycle after start is accepted through the last CHECK.
- done  out  1  one-cycle pulse when a run completes.
- pass  out  1  1 when the last run had zero mismatches; held until the next accepted start.
- err_count  out  N_IN+1  number of mismatching vectors in the current/last run; saturates at 2^N_IN.
- first_fail  out  N_IN  first mismatching vector; valid when err_count!=0.

Behaviour:
- Reset (async, rst_n=0): state=IDLE, dut_in=0, busy=0, done=0, pass=0, err_count=0, first_fail=0, settle counter=0. Reset mid-run aborts immediately; no done pulse is produced.
- States: IDLE, SETTLE, CHECK, DONE.
- IDLE → SETTLE: on start=1 at a clock edge.
  - Clear vec/dut_in to 0, err_count to 0, first_fail to 0, pass to 0.
  - Load the settle counter with SETTLE-1 and set busy=1.
- SETTLE: the counter decrements each cycle. When the counter reaches 0, go to CHECK. Each vector therefore spends exactly SETTLE cycles in SETTLE.
- CHECK (1 cycle): compare dut_out with expected(GATE_OP, dut_in).
  - On mismatch: err_count++ (saturating). If err_count==0 before this increment, first_fail<=dut_in.
  - If dut_in == 2^N_IN-1: go to DONE. Otherwise dut_in<=dut_in+1, reload the counter, go to SETTLE.
- DONE (1 cycle): done=1, busy=0, pass=(err_count==0) including the final CHECK's update; then go to IDLE.
- Latency: start accepted at edge 0; done high during cycle 2^N_IN*(SETTLE+1)+1. For N_IN=3, SETTLE=1 this is cycle 17.
- start while busy or in DONE is ignored. start held high in IDLE re-triggers a run on the cycle after DONE.
- dut_in changes only on the CHECK→SETTLE edge. It holds the last vector (all ones) through DONE/IDLE until the next start.
- Wrap-around: vec never wraps; the terminal vector always ends the run.
- Expected-function arithmetic is pure reduction over N_IN bits. err_count width N_IN+1 covers all 2^N_IN mismatches.

Optional Feature:
- Macro GATE_CHK_STOP_ON_FAIL_EN.
- Defined: the first mismatch in CHECK goes directly to DONE with err_count=1, first_fail=that vector, pass=0. dut_in holds the failing vector.
- Undefined: all 2^N_IN vectors are always exercised, as described under Behaviour.

Test Plan:
- Correct 3-input AND model (N_IN=3, GATE_OP=0, SETTLE=1), pulse start → dut_in steps 0..7, done pulses at cycle 17, pass=1, err_count=0.
- AND output stuck at 0 → err_count=1, first_fail=3'b111, pass=0.
- AND output stuck at 1 → err_count=7, first_fail=3'b000, pass=0.
- start re-pulsed at cycles 3 and 9 of a run → no restart, done still exactly at cycle 17, single done pulse.
- rst_n low at cycle 6 mid-run → all outputs 0 asynchronously, no done. Subsequent start → full clean run, pass=1.
- GATE_CHK_STOP_ON_FAIL_EN defined, output stuck at 1 → CHECK of vector 0 fails, done at cycle 3, err_count=1, first_fail=0, dut_in=0.
